// File: rtl/lift_pkg.sv
// ============================================================================
// Module      : lift_pkg
// Description : Shared types and slot-index helpers for the hall-call panel.
//               A slot is one (floor, direction) pair: s = 2*floor + dir,
//               dir 1 = up, 0 = down.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lift_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } hall_fsm_e;

    // Width of a floor number; never narrower than one bit.
    function automatic int floor_w(input int n_floors);
        return (n_floors > 1) ? $clog2(n_floors) : 1;
    endfunction

    // Width of a slot index covering 2*n_floors slots.
    function automatic int slot_w(input int n_floors);
        return $clog2(2 * n_floors);
    endfunction

    function automatic int slot_of(input int floor, input dir_e dir);
        return 2 * floor + int'(dir);
    endfunction

    function automatic int floor_of(input int s);
        return s / 2;
    endfunction

    function automatic dir_e dir_of(input int s);
        return ((s % 2) == 1) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage : lift_pkg

`default_nettype wire

// File: rtl/lift_rr_picker.sv
// ============================================================================
// Module      : lift_rr_picker
// Description : Combinational rotating-priority first-one finder. Scans
//               i_req starting at i_ptr, wrapping at N_REQ, and reports the
//               first set bit.
// Ports       : i_req   request vector
//               i_ptr   starting index of the scan
//               o_found at least one request is set
//               o_idx   index of the first request at or after i_ptr
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lift_rr_picker #(
    parameter int N_REQ = 24,
    parameter int IDX_W = 5
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_found && i_req[(int'(i_ptr) + i) % N_REQ]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'((int'(i_ptr) + i) % N_REQ);
            end
        end
    end

endmodule : lift_rr_picker

`default_nettype wire

// File: rtl/hall_call_panel.sv
// ============================================================================
// Module      : hall_call_panel
// Description : Hall-side call requester for the multi-lift arbiter.
//               Latches up/down hall-button edges into per-slot pending
//               flags, drives the lamps, offers pending undispatched calls
//               to the arbiter round-robin over valid/ready, and clears a
//               call when any lift reports service at that floor/direction.
// Ports       : clk, reset             clock, async active-high reset
//               btn_up / btn_down      raw hall buttons (top up / bottom
//                                      down are ignored)
//               call_valid/ready       offer handshake to the arbiter
//               call_floor/call_dir    offered call
//               svc_valid/floor/dir    per-lift service reports
//               lamp_up / lamp_down    pending-call lamps
//               pending_cnt            number of pending slots
// Options     : CALL_TIMEOUT_EN  when defined, a dispatched call that is not
//               serviced within about three TIMEOUT_CYCLES epochs is
//               released and offered again.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hall_call_panel
    import lift_pkg::*;
#(
    parameter int N_FLOORS       = 12,
    parameter int N_LIFTS        = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_FLOORS-1:0]                  btn_up,
    input  logic [N_FLOORS-1:0]                  btn_down,
    output logic                                 call_valid,
    input  logic                                 call_ready,
    output logic [floor_w(N_FLOORS)-1:0]         call_floor,
    output logic                                 call_dir,
    input  logic [N_LIFTS-1:0]                   svc_valid,
    input  logic [N_LIFTS*floor_w(N_FLOORS)-1:0] svc_floor,
    input  logic [N_LIFTS-1:0]                   svc_dir,
    output logic [N_FLOORS-1:0]                  lamp_up,
    output logic [N_FLOORS-1:0]                  lamp_down,
    output logic [$clog2(2*N_FLOORS+1)-1:0]      pending_cnt
);

    localparam int FLOOR_W = floor_w(N_FLOORS);
    localparam int N_SLOTS = 2 * N_FLOORS;
    localparam int SLOT_W  = slot_w(N_FLOORS);
    localparam int CNT_W   = $clog2(N_SLOTS + 1);

    // The top floor has no up button and the ground floor no down button.
    localparam logic [N_FLOORS-1:0] c_up_legal   = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] c_down_legal = {{(N_FLOORS-1){1'b1}}, 1'b0};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [N_FLOORS-1:0] r_btn_up_prev;
    logic [N_FLOORS-1:0] r_btn_down_prev;
    logic [N_SLOTS-1:0]  r_pending;
    logic [N_SLOTS-1:0]  r_dispatched;
    logic [SLOT_W-1:0]   r_ptr;
    hall_fsm_e           r_state;
    logic                r_call_valid;
    logic [FLOOR_W-1:0]  r_call_floor;
    logic                r_call_dir;
    logic [SLOT_W-1:0]   r_call_slot;
    logic [CNT_W-1:0]    r_cnt;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [N_FLOORS-1:0] w_rise_up;
    logic [N_FLOORS-1:0] w_rise_down;
    logic [N_SLOTS-1:0]  w_rise;
    logic [N_SLOTS-1:0]  w_svc_clr;
    logic [N_SLOTS-1:0]  w_to_clr;
    logic [N_SLOTS-1:0]  w_hs_set;
    logic [N_SLOTS-1:0]  w_pending_next;
    logic [N_SLOTS-1:0]  w_dispatched_next;
    logic [N_SLOTS-1:0]  w_req;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_pick_found;
    logic [SLOT_W-1:0]   w_pick_idx;
    hall_fsm_e           w_state_next;
    logic                w_call_valid_next;
    logic [FLOOR_W-1:0]  w_call_floor_next;
    logic                w_call_dir_next;
    logic [SLOT_W-1:0]   w_call_slot_next;
    logic [SLOT_W-1:0]   w_ptr_next;

    // ------------------------------------------------------------------------
    // Button edge detection, mapped onto slots
    // ------------------------------------------------------------------------
    assign w_rise_up   = btn_up   & ~r_btn_up_prev   & c_up_legal;
    assign w_rise_down = btn_down & ~r_btn_down_prev & c_down_legal;

    always_comb begin
        w_rise = '0;
        for (int f = 0; f < N_FLOORS; f++) begin
            w_rise[slot_of(f, DIR_UP)]   = w_rise_up[f];
            w_rise[slot_of(f, DIR_DOWN)] = w_rise_down[f];
        end
    end

    // ------------------------------------------------------------------------
    // Service clears: OR over all lifts; out-of-range floors are dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        w_svc_clr = '0;
        for (int l = 0; l < N_LIFTS; l++) begin
            if (svc_valid[l] && (int'(svc_floor[l*FLOOR_W +: FLOOR_W]) < N_FLOORS)) begin
                w_svc_clr[slot_of(int'(svc_floor[l*FLOOR_W +: FLOOR_W]),
                                  svc_dir[l] ? DIR_UP : DIR_DOWN)] = 1'b1;
            end
        end
    end

    // Service has priority over a same-cycle press and a same-cycle dispatch.
    assign w_pending_next    = (r_pending | w_rise) & ~w_svc_clr;
    assign w_dispatched_next = (r_dispatched | w_hs_set) & ~w_svc_clr & ~w_to_clr;

    // Count the next pending vector so the count lands with the lamps.
    always_comb begin
        w_cnt_next = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            w_cnt_next = w_cnt_next + CNT_W'(w_pending_next[s]);
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin selection. Slots being serviced this cycle are masked so a
    // call is never offered after its lift has already arrived.
    // ------------------------------------------------------------------------
    assign w_req = r_pending & ~r_dispatched & ~w_svc_clr;

    lift_rr_picker #(
        .N_REQ (N_SLOTS),
        .IDX_W (SLOT_W)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // ------------------------------------------------------------------------
    // Offer FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_call_valid_next = r_call_valid;
        w_call_floor_next = r_call_floor;
        w_call_dir_next   = r_call_dir;
        w_call_slot_next  = r_call_slot;
        w_ptr_next        = r_ptr;
        w_hs_set          = '0;

        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_next      = OFFER;
                    w_call_valid_next = 1'b1;
                    w_call_slot_next  = w_pick_idx;
                    w_call_floor_next = FLOOR_W'(floor_of(int'(w_pick_idx)));
                    w_call_dir_next   = (dir_of(int'(w_pick_idx)) == DIR_UP);
                end
            end
            OFFER: begin
                if (r_call_valid && call_ready) begin
                    // Handshake wins over a same-cycle service; the service
                    // still clears the dispatched flag through w_svc_clr.
                    w_hs_set[r_call_slot] = 1'b1;
                    w_ptr_next        = (r_call_slot == SLOT_W'(N_SLOTS - 1)) ?
                                        '0 : (r_call_slot + 1'b1);
                    w_state_next      = IDLE;
                    w_call_valid_next = 1'b0;
                end else if (w_svc_clr[r_call_slot]) begin
                    // Offered call serviced before acceptance: withdraw it.
                    w_state_next      = IDLE;
                    w_call_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next      = IDLE;
                w_call_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_up_prev   <= '0;
            r_btn_down_prev <= '0;
            r_pending       <= '0;
            r_dispatched    <= '0;
            r_ptr           <= '0;
            r_call_valid    <= 1'b0;
            r_call_floor    <= '0;
            r_call_dir      <= 1'b0;
            r_call_slot     <= '0;
            r_cnt           <= '0;
        end else begin
            r_btn_up_prev   <= btn_up;
            r_btn_down_prev <= btn_down;
            r_pending       <= w_pending_next;
            r_dispatched    <= w_dispatched_next;
            r_ptr           <= w_ptr_next;
            r_call_valid    <= w_call_valid_next;
            r_call_floor    <= w_call_floor_next;
            r_call_dir      <= w_call_dir_next;
            r_call_slot     <= w_call_slot_next;
            r_cnt           <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Dispatch aging
    // ------------------------------------------------------------------------
`ifdef CALL_TIMEOUT_EN
    localparam int EPOCH_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [EPOCH_W-1:0]          r_epoch_cnt;
    logic [N_SLOTS-1:0][1:0]     r_age;
    logic                        w_epoch_pulse;

    assign w_epoch_pulse = (r_epoch_cnt == EPOCH_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epoch_cnt <= '0;
            r_age       <= '0;
        end else begin
            r_epoch_cnt <= w_epoch_pulse ? '0 : (r_epoch_cnt + 1'b1);
            for (int s = 0; s < N_SLOTS; s++) begin
                // Age only runs while a slot stays dispatched.
                if (w_hs_set[s] || !w_dispatched_next[s]) begin
                    r_age[s] <= 2'd0;
                end else if (w_epoch_pulse && (r_age[s] != 2'd3)) begin
                    r_age[s] <= r_age[s] + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_to_clr = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            w_to_clr[s] = r_dispatched[s] && (r_age[s] == 2'd3);
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_to_clr = '0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    for (genvar f = 0; f < N_FLOORS; f++) begin : g_lamp
        assign lamp_up[f]   = r_pending[2*f + 1];
        assign lamp_down[f] = r_pending[2*f];
    end

    assign call_valid  = r_call_valid;
    assign call_floor  = r_call_floor;
    assign call_dir    = r_call_dir;
    assign pending_cnt = r_cnt;

endmodule : hall_call_panel

`default_nettype wire

// File: tb/tb_hall_call_panel.sv
// ============================================================================
// Module      : tb_hall_call_panel
// Description : Directed self-checking bench for hall_call_panel (default
//               build, 12 floors, 10 lifts). Inputs change on the falling
//               edge; outputs are sampled on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hall_call_panel;

    localparam int NF = 12;
    localparam int NL = 10;
    localparam int FW = 4;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NF-1:0]     btn_up;
    logic [NF-1:0]     btn_down;
    logic              call_valid;
    logic              call_ready;
    logic [FW-1:0]     call_floor;
    logic              call_dir;
    logic [NL-1:0]     svc_valid;
    logic [NL*FW-1:0]  svc_floor;
    logic [NL-1:0]     svc_dir;
    logic [NF-1:0]     lamp_up;
    logic [NF-1:0]     lamp_down;
    logic [CW-1:0]     pending_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Accepted calls as {floor, dir}.
    logic [4:0] acc_q[$];

    hall_call_panel #(
        .N_FLOORS       (NF),
        .N_LIFTS        (NL),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .call_valid  (call_valid),
        .call_ready  (call_ready),
        .call_floor  (call_floor),
        .call_dir    (call_dir),
        .svc_valid   (svc_valid),
        .svc_floor   (svc_floor),
        .svc_dir     (svc_dir),
        .lamp_up     (lamp_up),
        .lamp_down   (lamp_down),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && call_valid && call_ready) begin
            acc_q.push_back({call_floor, call_dir});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_svc(input int lift, input int fl, input logic dir);
        svc_valid[lift]          = 1'b1;
        svc_floor[lift*FW +: FW] = FW'(fl);
        svc_dir[lift]            = dir;
    endtask

    task automatic clr_svc();
        svc_valid = '0;
        svc_floor = '0;
        svc_dir   = '0;
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int k = 0;
        while (!call_valid && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(call_valid), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        btn_up     = '0;
        btn_down   = '0;
        call_ready = 1'b0;
        svc_valid  = '0;
        svc_floor  = '0;
        svc_dir    = '0;

        // ---------------- reset state ----------------
        cyc(1);
        chk("rst_valid", 32'(call_valid),  32'd0);
        chk("rst_floor", 32'(call_floor),  32'd0);
        chk("rst_dir",   32'(call_dir),    32'd0);
        chk("rst_lampu", 32'(lamp_up),     32'd0);
        chk("rst_lampd", 32'(lamp_down),   32'd0);
        chk("rst_cnt",   32'(pending_cnt), 32'd0);
        reset = 1'b0;
        cyc(1);

        // ---------------- A: single up call at floor 3 ----------------
        btn_up[3]  = 1'b1;
        call_ready = 1'b1;
        cyc(1);
        chk("A_lamp",   32'(lamp_up),     32'h008);
        chk("A_cnt",    32'(pending_cnt), 32'd1);
        chk("A_v0",     32'(call_valid),  32'd0);
        btn_up = '0;
        cyc(1);
        chk("A_valid",  32'(call_valid),  32'd1);
        chk("A_floor",  32'(call_floor),  32'd3);
        chk("A_dir",    32'(call_dir),    32'd1);
        cyc(1);
        chk("A_vdrop",  32'(call_valid),  32'd0);
        cyc(6);
        chk("A_nacc",   32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("A_acc0", 32'(acc_q[0]), 32'h07);
        chk("A_noreoff", 32'(call_valid), 32'd0);
        chk("A_lamp_hold", 32'(lamp_up),  32'h008);
        set_svc(0, 3, 1'b1);
        cyc(1);
        chk("A_svc_lamp", 32'(lamp_up),     32'd0);
        chk("A_svc_cnt",  32'(pending_cnt), 32'd0);
        clr_svc();
        acc_q.delete();

        // ---------------- B: held down button at floor 5 ----------------
        btn_down[5] = 1'b1;
        cyc(1);
        chk("B_lamp", 32'(lamp_down),   32'h020);
        chk("B_cnt",  32'(pending_cnt), 32'd1);
        cyc(9);
        btn_down = '0;
        chk("B_nacc", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("B_acc0", 32'(acc_q[0]), 32'h0A);
        set_svc(2, 5, 1'b0);
        cyc(1);
        chk("B_svc_lamp", 32'(lamp_down),   32'd0);
        chk("B_svc_cnt",  32'(pending_cnt), 32'd0);
        clr_svc();
        cyc(2);
        chk("B_nacc2", 32'(acc_q.size()), 32'd1);
        acc_q.delete();

        // ---------------- C: round robin from ptr 0, then wrap -----------
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        acc_q.delete();
        btn_up = 12'h282;                   // floors 1, 7, 9
        cyc(1);
        btn_up = '0;
        chk("C_lamp", 32'(lamp_up),     32'h282);
        chk("C_cnt",  32'(pending_cnt), 32'd3);
        cyc(10);
        chk("C_nacc", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() > 2) begin
            chk("C_acc0", 32'(acc_q[0]), 32'h03);
            chk("C_acc1", 32'(acc_q[1]), 32'h0F);
            chk("C_acc2", 32'(acc_q[2]), 32'h13);
        end
        set_svc(0, 1, 1'b1);
        set_svc(1, 7, 1'b1);
        set_svc(2, 9, 1'b1);
        set_svc(3, 7, 1'b1);                // duplicate slot, same cycle
        cyc(1);
        chk("C_svc_lamp", 32'(lamp_up),     32'd0);
        chk("C_svc_cnt",  32'(pending_cnt), 32'd0);
        clr_svc();
        acc_q.delete();
        btn_up = 12'h402;                   // floors 1 and 10, ptr at slot 20
        cyc(1);
        btn_up = '0;
        chk("W_cnt", 32'(pending_cnt), 32'd2);
        cyc(8);
        chk("W_nacc", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() > 1) begin
            chk("W_acc0", 32'(acc_q[0]), 32'h15);
            chk("W_acc1", 32'(acc_q[1]), 32'h03);
        end
        set_svc(4, 10, 1'b1);
        set_svc(5, 1, 1'b1);
        cyc(1);
        chk("W_svc_cnt", 32'(pending_cnt), 32'd0);
        clr_svc();
        acc_q.delete();

        // ---------------- D: cancel of an unaccepted offer ----------------
        call_ready = 1'b0;
        btn_up[4]  = 1'b1;
        cyc(1);
        btn_up = '0;
        wait_valid("D_offer", 5);
        chk("D_floor", 32'(call_floor), 32'd4);
        chk("D_dir",   32'(call_dir),   32'd1);
        cyc(3);
        chk("D_hold_v", 32'(call_valid), 32'd1);
        chk("D_hold_f", 32'(call_floor), 32'd4);
        chk("D_lamp",   32'(lamp_up),    32'h010);
        set_svc(6, 13, 1'b1);               // floor beyond the building
        cyc(1);
        chk("D_ill_v",    32'(call_valid), 32'd1);
        chk("D_ill_lamp", 32'(lamp_up),    32'h010);
        clr_svc();
        set_svc(7, 4, 1'b1);
        cyc(1);
        chk("D_cancel_v", 32'(call_valid),  32'd0);
        chk("D_cancel_l", 32'(lamp_up),     32'd0);
        chk("D_cancel_c", 32'(pending_cnt), 32'd0);
        clr_svc();
        call_ready = 1'b1;
        cyc(5);
        chk("D_post_v",  32'(call_valid),   32'd0);
        chk("D_post_n",  32'(acc_q.size()), 32'd0);

        // ---------------- E: illegal buttons ----------------
        btn_up   = 12'h800;
        btn_down = 12'h001;
        cyc(1);
        btn_up   = '0;
        btn_down = '0;
        cyc(5);
        chk("E_lampu", 32'(lamp_up),       32'd0);
        chk("E_lampd", 32'(lamp_down),     32'd0);
        chk("E_cnt",   32'(pending_cnt),   32'd0);
        chk("E_valid", 32'(call_valid),    32'd0);
        chk("E_nacc",  32'(acc_q.size()),  32'd0);

        // ---------------- F: press and service in the same cycle ----------
        call_ready = 1'b0;
        btn_up[2]  = 1'b1;
        set_svc(8, 2, 1'b1);
        cyc(1);
        clr_svc();
        btn_up = '0;
        chk("F_lamp", 32'(lamp_up),     32'd0);
        chk("F_cnt",  32'(pending_cnt), 32'd0);
        cyc(3);
        chk("F_valid", 32'(call_valid), 32'd0);

        // ---------------- G: press on an already pending slot -------------
        call_ready  = 1'b1;
        btn_down[6] = 1'b1;
        cyc(1);
        btn_down = '0;
        cyc(4);
        chk("G_nacc", 32'(acc_q.size()), 32'd1);
        btn_down[6] = 1'b1;
        cyc(1);
        btn_down = '0;
        cyc(5);
        chk("G_nacc2", 32'(acc_q.size()), 32'd1);
        chk("G_cnt",   32'(pending_cnt),  32'd1);
        chk("G_valid", 32'(call_valid),   32'd0);

        // ---------------- H: asynchronous reset mid-offer ----------------
        call_ready = 1'b0;
        btn_up[8]  = 1'b1;
        cyc(1);
        btn_up = '0;
        wait_valid("H_offer", 5);
        chk("H_pre_cnt", 32'(pending_cnt), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("H_valid", 32'(call_valid),  32'd0);
        chk("H_lampu", 32'(lamp_up),     32'd0);
        chk("H_lampd", 32'(lamp_down),   32'd0);
        chk("H_cnt",   32'(pending_cnt), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(3);
        chk("H_post_v", 32'(call_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_hall_call_panel

`default_nettype wire
